// File: rtl/lfsr_prng_ctrl_if.sv
// Word-stream interface for the LFSR generator: control and load inputs plus
// the valid/ready output stream with its status outputs.
interface lfsr_prng_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] taps;
    logic             ready;
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             done;
    logic [WIDTH-1:0] period;
    logic             lockup;

    modport master (
        output enable, load, seed, taps, ready,
        input  valid, data, done, period, lockup
    );

    modport slave (
        input  enable, load, seed, taps, ready,
        output valid, data, done, period, lockup
    );
endinterface

// File: rtl/lfsr_prng_ctrl.sv
// Runtime-programmable Fibonacci XOR LFSR with a valid/ready word stream,
// period measurement, a wrap pulse and zero-state lock-up recovery.
//
//   state | meaning
//   IDLE  | not offering words, LFSR state held
//   RUN   | offering the current state as a word each cycle
module lfsr_prng_ctrl #(
    parameter int               WIDTH        = 4,
    parameter logic [WIDTH-1:0] DEFAULT_TAPS = 4'hC,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'h1
) (
    input logic              i_clk,
    input logic              i_rst,
    lfsr_prng_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    fsm_t             fsm;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_reg;
    logic [WIDTH-1:0] taps;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;
    logic [WIDTH-1:0] nxt;
    logic             fb;
    logic             advance;
    logic             valid;
    logic             done;
    logic [WIDTH-1:0] period;
    logic             lockup;

    always_comb begin
        fb        = ^(state & taps);
        nxt       = {state[WIDTH-2:0], fb};
        count_inc = (&count) ? count : count + ONE;
        // A word offered while enable drops is not consumed, so the state
        // is still there when the stream resumes.
        advance   = valid && bus.ready && bus.enable;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            fsm      <= IDLE;
            state    <= DEFAULT_SEED;
            seed_reg <= DEFAULT_SEED;
            taps     <= DEFAULT_TAPS;
            count    <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            period   <= '0;
            lockup   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.load) begin
                if (bus.seed == '0) begin
                    seed_reg <= ONE;
                    state    <= ONE;
                    lockup   <= 1'b1;
                end else begin
                    seed_reg <= bus.seed;
                    state    <= bus.seed;
                    lockup   <= 1'b0;
                end
                taps  <= (bus.taps == '0) ? DEFAULT_TAPS : bus.taps;
                count <= '0;
                fsm   <= bus.enable ? RUN : IDLE;
                valid <= bus.enable;
            end else begin
                if (advance) begin
                    if (nxt == '0) begin
                        state  <= seed_reg;
                        lockup <= 1'b1;
                        count  <= '0;
                    end else if (nxt == seed_reg) begin
                        state  <= nxt;
                        done   <= 1'b1;
                        period <= count_inc;
                        count  <= '0;
                    end else begin
                        state <= nxt;
                        count <= count_inc;
                    end
                end
                case (fsm)
                    IDLE: if (bus.enable) begin
                        fsm   <= RUN;
                        valid <= 1'b1;
                    end
                    RUN: if (!bus.enable) begin
                        fsm   <= IDLE;
                        valid <= 1'b0;
                    end
                    default: begin
                        fsm   <= IDLE;
                        valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.valid  = valid;
    assign bus.data   = state;
    assign bus.done   = done;
    assign bus.period = period;
    assign bus.lockup = lockup;
endmodule
